regs_multi: RTL
===============

Name: regs_multi

Overview:
Parametrised successor of the single-port control register block. It exposes NUM_PORTS per-port CTRL/STATUS register pairs and a global interrupt summary register on one req/ack register bus. Per port it adds sticky write-1-to-clear error capture, an interrupt enable and unmapped-address error responses. It sits between the config bus master and the per-port datapath controllers.

Parameters:
NUM_PORTS, 4, number of port register banks (1..8)
ADDR_SIZE_P, 4, register address width; requires 2*NUM_PORTS+1 <= 2**ADDR_SIZE_P
PORT_ID_W, 4, width of each port_id field (1..8)
RESET_PORT_ID_BASE, 0, reset port_id of port p is RESET_PORT_ID_BASE+p, truncated to PORT_ID_W

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
addr  in  ADDR_SIZE_P  register address, sampled with req
rd_wr  in  1  1=read, 0=write
req  in  1  request level; held high by master until ack seen
write_val  in  32  write data, sampled with req
read_val  out  32  read data, valid in ack cycle, held afterwards
ack  out  1  one-cycle completion pulse
resp_err  out  1  valid with ack; 1 = unmapped address
cfg_ctrl_err  in  NUM_PORTS  per-port error event (level, sampled every cycle)
cfg_ctrl_idle  in  NUM_PORTS  per-port idle status (live)
cfg_port_enable  out  NUM_PORTS  per-port enable
cfg_port_id  out  NUM_PORTS*PORT_ID_W  port p occupies bits [p*PORT_ID_W +: PORT_ID_W]
irq  out  1  OR over p of (err_sticky[p] & err_int_en[p])

Behaviour:
- Address map, for p in 0..NUM_PORTS-1:
  - 2p = CTRL: bit0 enable (RW); bits[PORT_ID_W:1] port_id (RW); all other bits read 0.
  - 2p+1 = STATUS: bit0 err_sticky (R/W1C); bit1 idle (RO, live cfg_ctrl_idle[p]); bit2 err_int_en (RW); all other bits read 0.
  - 2*NUM_PORTS = INT_STATUS (RO): bit p = err_sticky[p] & err_int_en[p].
  - All higher addresses are unmapped.
- Reset values (reset high at a clock edge):
  - enable=0, port_id=RESET_PORT_ID_BASE+p, err_sticky=0, err_int_en=0.
  - ack=0, resp_err=0, read_val=0, FSM=IDLE, irq=0.
- Handshake FSM, states IDLE, ACK, WAIT_LOW:
  - IDLE: req=1 captures addr/rd_wr/write_val and goes to ACK.
  - ACK: lasts exactly one cycle with ack=1. Write commits at the edge entering ACK, so cfg outputs change in the same cycle ack rises. read_val/resp_err are loaded at that same edge.
  - ACK -> WAIT_LOW if req=1, else -> IDLE.
  - WAIT_LOW -> IDLE when req=0. Further req levels are ignored until req has been seen low, so a held req never produces a second transaction.
  - Latency: req high in cycle N gives ack in cycle N+1. Minimum spacing is 3 cycles per transaction when req is dropped on ack.
- Unmapped access: ack with resp_err=1. A read returns read_val=0; a write has no effect.
- Writes to RO fields and reserved bits are ignored. A write to INT_STATUS is ignored with resp_err=0.
- err_sticky[p]:
  - Set in any cycle cfg_ctrl_err[p]=1.
  - Cleared by a STATUS write with bit0=1.
  - Simultaneous set and clear: set wins (result 1).
- irq is combinational from registered state, so it rises the cycle after the error is captured.
- Reads return register state before the write-commit edge; the read is sampled at the same edge that captures err events.
- Reset mid-transaction: the FSM returns to IDLE and ack is 0 in the next cycle; the transaction is discarded. The master must re-issue req after reset deasserts.
- read_val holds its last value outside ack cycles.

Decomposition:
- Shared package regs_pkg holds:
  - FSM state encoding (IDLE/ACK/WAIT_LOW);
  - CTRL/STATUS offsets and field bit positions (CTRL_EN_BIT, CTRL_ID_LSB, ST_ERR_BIT, ST_IDLE_BIT, ST_IEN_BIT);
  - the INT_STATUS address function of NUM_PORTS.
- One sub-module, regs_port_bank: a single port's CTRL+STATUS storage, sticky logic and read mux. It is generated NUM_PORTS times.
- Top level keeps the FSM, address decode, global read mux and irq reduction.

Test Plan:
- Reset, NUM_PORTS=4, BASE=2: read CTRL of ports 0..3 -> read_val = 0x4, 0x6, 0x8, 0xA (port_id<<1, enable=0). irq=0, resp_err=0.
- Write CTRL port 2 = 0x0000001B -> cfg_port_enable[2]=1 and cfg_port_id[11:8]=0xD in the ack cycle. Other ports unchanged. Readback = 0x1B.
- Pulse cfg_ctrl_err[1] one cycle with STATUS1 bit2 set beforehand:
  - STATUS1 reads 0x5 (0x7 if idle[1]=1); irq=1; INT_STATUS=0x2.
  - Write STATUS1 = 0x5 (W1C bit0, keep err_int_en) -> irq=0.
- Hold cfg_ctrl_err[1]=1 while writing STATUS1 bit0=1 -> err_sticky stays 1 and irq stays 1.
- Read addr 0xF (unmapped) -> ack with resp_err=1, read_val=0. Write 0xF -> no state change.
- Hold req high 6 cycles -> exactly one ack pulse.
- Assert reset during the ACK cycle of a write to CTRL0 -> next cycle ack=0 and enable[0]=0.

Source files
------------

// File: rtl/regs_pkg.sv
// Shared definitions for the multi-port register block: handshake states,
// register offsets within a port bank, field positions and the INT_STATUS address.
package regs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACK,
        ST_WAIT_LOW
    } hs_state_t;

    // Each port owns two consecutive addresses: CTRL then STATUS
    localparam int unsigned REGS_PER_PORT = 2;
    localparam int unsigned CTRL_OFFSET   = 0;
    localparam int unsigned STATUS_OFFSET = 1;

    // CTRL fields
    localparam int unsigned CTRL_EN_BIT = 0;
    localparam int unsigned CTRL_ID_LSB = 1;

    // STATUS fields
    localparam int unsigned ST_ERR_BIT  = 0;
    localparam int unsigned ST_IDLE_BIT = 1;
    localparam int unsigned ST_IEN_BIT  = 2;

    // INT_STATUS sits directly after the last port bank
    function automatic int unsigned int_status_addr(input int unsigned num_ports);
        return REGS_PER_PORT * num_ports;
    endfunction

endpackage

// File: rtl/regs_port_bank.sv
// One port's CTRL/STATUS register pair: enable, port_id, sticky error with
// write-1-to-clear, interrupt enable, and the read-data view of both registers.
module regs_port_bank
    import regs_pkg::*;
#(
    parameter int                   PORT_ID_W = 4,
    parameter logic [PORT_ID_W-1:0] RESET_ID  = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ctrl_we,
    input  logic                 status_we,
    input  logic [PORT_ID_W:0]   ctrl_wdata,
    input  logic [2:0]           status_wdata,
    input  logic                 err_evt,
    input  logic                 idle,
    output logic                 enable,
    output logic [PORT_ID_W-1:0] port_id,
    output logic                 err_sticky,
    output logic                 err_int_en,
    output logic [31:0]          ctrl_rd,
    output logic [31:0]          status_rd
);

    // CTRL register: enable and port_id
    always_ff @(posedge clk) begin
        if (reset) begin
            enable  <= 1'b0;
            port_id <= RESET_ID;
        end else if (ctrl_we) begin
            enable  <= ctrl_wdata[CTRL_EN_BIT];
            port_id <= ctrl_wdata[CTRL_ID_LSB +: PORT_ID_W];
        end
    end

    // STATUS register: sticky error (a new event beats a W1C clear) and interrupt enable
    always_ff @(posedge clk) begin
        if (reset) begin
            err_sticky <= 1'b0;
            err_int_en <= 1'b0;
        end else begin
            if (err_evt) begin
                err_sticky <= 1'b1;
            end else if (status_we && status_wdata[ST_ERR_BIT]) begin
                err_sticky <= 1'b0;
            end
            if (status_we) begin
                err_int_en <= status_wdata[ST_IEN_BIT];
            end
        end
    end

    // Read views; reserved bits read as zero, idle is the live input
    always_comb begin
        ctrl_rd                             = '0;
        ctrl_rd[CTRL_EN_BIT]                = enable;
        ctrl_rd[CTRL_ID_LSB +: PORT_ID_W]   = port_id;
        status_rd                           = '0;
        status_rd[ST_ERR_BIT]               = err_sticky;
        status_rd[ST_IDLE_BIT]              = idle;
        status_rd[ST_IEN_BIT]               = err_int_en;
    end

endmodule

// File: rtl/regs_multi.sv
// Multi-port control/status register block on a req/ack register bus.
// Holds the handshake FSM, address decode, global read mux and irq summary;
// per-port storage lives in regs_port_bank.
module regs_multi
    import regs_pkg::*;
#(
    parameter int NUM_PORTS          = 4,
    parameter int ADDR_SIZE_P        = 4,
    parameter int PORT_ID_W          = 4,
    parameter int RESET_PORT_ID_BASE = 0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [ADDR_SIZE_P-1:0]         addr,
    input  logic                           rd_wr,
    input  logic                           req,
    input  logic [31:0]                    write_val,
    output logic [31:0]                    read_val,
    output logic                           ack,
    output logic                           resp_err,
    input  logic [NUM_PORTS-1:0]           cfg_ctrl_err,
    input  logic [NUM_PORTS-1:0]           cfg_ctrl_idle,
    output logic [NUM_PORTS-1:0]           cfg_port_enable,
    output logic [NUM_PORTS*PORT_ID_W-1:0] cfg_port_id,
    output logic                           irq
);

    localparam logic [ADDR_SIZE_P-1:0] INT_ADDR = ADDR_SIZE_P'(int_status_addr(NUM_PORTS));

    hs_state_t              state;
    logic                   wr_go;
    logic                   mapped;
    logic [31:0]            rd_mux;
    logic [NUM_PORTS-1:0]   ctrl_we;
    logic [NUM_PORTS-1:0]   status_we;
    logic [NUM_PORTS-1:0]   err_sticky;
    logic [NUM_PORTS-1:0]   err_int_en;
    logic [NUM_PORTS-1:0]   int_bits;
    logic [31:0]            ctrl_rd   [NUM_PORTS];
    logic [31:0]            status_rd [NUM_PORTS];
    logic                   unused_wdata;

    assign unused_wdata = ^write_val[31:PORT_ID_W+1];

    // The write commits on the same edge that enters ACK, so no request capture registers are needed
    assign wr_go = (state == ST_IDLE) && req && !rd_wr;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        localparam logic [PORT_ID_W-1:0] RID = PORT_ID_W'(RESET_PORT_ID_BASE + p);

        regs_port_bank #(
            .PORT_ID_W (PORT_ID_W),
            .RESET_ID  (RID)
        ) u_bank (
            .clk          (clk),
            .reset        (reset),
            .ctrl_we      (ctrl_we[p]),
            .status_we    (status_we[p]),
            .ctrl_wdata   (write_val[PORT_ID_W:0]),
            .status_wdata (write_val[2:0]),
            .err_evt      (cfg_ctrl_err[p]),
            .idle         (cfg_ctrl_idle[p]),
            .enable       (cfg_port_enable[p]),
            .port_id      (cfg_port_id[p*PORT_ID_W +: PORT_ID_W]),
            .err_sticky   (err_sticky[p]),
            .err_int_en   (err_int_en[p]),
            .ctrl_rd      (ctrl_rd[p]),
            .status_rd    (status_rd[p])
        );
    end

    assign int_bits = err_sticky & err_int_en;
    assign irq      = |int_bits;

    // Address decode: per-port write strobes, read data and mapped flag
    always_comb begin
        ctrl_we   = '0;
        status_we = '0;
        rd_mux    = '0;
        mapped    = 1'b0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (addr == ADDR_SIZE_P'(REGS_PER_PORT*i + CTRL_OFFSET)) begin
                ctrl_we[i] = wr_go;
                rd_mux     = ctrl_rd[i];
                mapped     = 1'b1;
            end
            if (addr == ADDR_SIZE_P'(REGS_PER_PORT*i + STATUS_OFFSET)) begin
                status_we[i] = wr_go;
                rd_mux       = status_rd[i];
                mapped       = 1'b1;
            end
        end
        if (addr == INT_ADDR) begin
            rd_mux[NUM_PORTS-1:0] = int_bits;
            mapped                = 1'b1;
        end
    end

    // Handshake FSM with registered ack/resp_err/read_val; read_val only updates on reads
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            ack      <= 1'b0;
            resp_err <= 1'b0;
            read_val <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        state    <= ST_ACK;
                        ack      <= 1'b1;
                        resp_err <= ~mapped;
                        if (rd_wr) begin
                            read_val <= rd_mux;
                        end
                    end
                end
                ST_ACK: begin
                    ack   <= 1'b0;
                    state <= req ? ST_WAIT_LOW : ST_IDLE;
                end
                ST_WAIT_LOW: begin
                    if (!req) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    ack   <= 1'b0;
                end
            endcase
        end
    end

endmodule
